// File: rtl/synchro_vga.sv
// VGA timing generator: pixel counters, blanking and registered pins with aligned sync.
// Optional colour-bar test pattern: define SYNCHRO_VGA_MIRE_EN to add the mire input.
module synchro_vga #(
    parameter int   DIV      = 2,
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] rouge,
    input  logic [2:0] vert,
    input  logic [1:0] bleu,
`ifdef SYNCHRO_VGA_MIRE_EN
    input  logic       mire,
`endif
    output logic [9:0] pixelX,
    output logic [9:0] pixelY,
    output logic       actif,
    output logic [2:0] vga_rouge,
    output logic [2:0] vga_vert,
    output logic [1:0] vga_bleu,
    output logic       hsync,
    output logic       vsync,
    output logic       fin_trame
);

    localparam int         H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int         V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [1:0] DIV_LAST = 2'(DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [1:0] r_div;
    logic [9:0] r_hcount;
    logic [9:0] r_vcount;
    logic [2:0] r_vga_rouge;
    logic [2:0] r_vga_vert;
    logic [1:0] r_vga_bleu;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_fin_trame;

    logic       w_tick;
    logic       w_hlast;
    logic       w_vlast;
    logic       w_actif;
    logic       w_hs_on;
    logic       w_vs_on;
    logic [2:0] w_rouge;
    logic [2:0] w_vert;
    logic [1:0] w_bleu;

    assign w_tick  = (r_div == DIV_LAST);
    assign w_hlast = (r_hcount == H_LAST);
    assign w_vlast = (r_vcount == V_LAST);
    assign w_actif = (r_hcount < H_ACT) && (r_vcount < V_ACT);
    assign w_hs_on = (r_hcount >= HS_START) && (r_hcount < HS_END);
    assign w_vs_on = (r_vcount >= VS_START) && (r_vcount < VS_END);

    // Stage 0: pixel clock divider and raster counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div    <= 2'd0;
            r_hcount <= 10'd0;
            r_vcount <= 10'd0;
        end else begin
            r_div <= w_tick ? 2'd0 : r_div + 2'd1;
            if (w_tick) begin
                if (w_hlast) begin
                    r_hcount <= 10'd0;
                    r_vcount <= w_vlast ? 10'd0 : r_vcount + 10'd1;
                end else begin
                    r_hcount <= r_hcount + 10'd1;
                end
            end
        end
    end

    always_comb begin
        w_rouge = rouge;
        w_vert  = vert;
        w_bleu  = bleu;
`ifdef SYNCHRO_VGA_MIRE_EN
        // Bar index is pixelX[9:7]; each index bit enables one full-scale primary
        if (mire) begin
            w_rouge = r_hcount[9] ? 3'd7 : 3'd0;
            w_vert  = r_hcount[8] ? 3'd7 : 3'd0;
            w_bleu  = r_hcount[7] ? 2'd3 : 2'd0;
        end
`endif
    end

    // Stage 1: one-pixel registered output; sync decoded from the same counters as colour
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vga_rouge <= 3'd0;
            r_vga_vert  <= 3'd0;
            r_vga_bleu  <= 2'd0;
            r_hsync     <= ~SYNC_POL;
            r_vsync     <= ~SYNC_POL;
            r_fin_trame <= 1'b0;
        end else begin
            r_fin_trame <= w_tick & w_hlast & w_vlast;
            if (w_tick) begin
                r_vga_rouge <= w_actif ? w_rouge : 3'd0;
                r_vga_vert  <= w_actif ? w_vert  : 3'd0;
                r_vga_bleu  <= w_actif ? w_bleu  : 2'd0;
                r_hsync     <= w_hs_on ? SYNC_POL : ~SYNC_POL;
                r_vsync     <= w_vs_on ? SYNC_POL : ~SYNC_POL;
            end
        end
    end

    assign pixelX    = r_hcount;
    assign pixelY    = r_vcount;
    assign actif     = w_actif;
    assign vga_rouge = r_vga_rouge;
    assign vga_vert  = r_vga_vert;
    assign vga_bleu  = r_vga_bleu;
    assign hsync     = r_hsync;
    assign vsync     = r_vsync;
    assign fin_trame = r_fin_trame;

endmodule
